// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: elastic buffer behind the UART receiver.
// Takes single-cycle byte strobes that ignore backpressure and re-presents
// them as a back-pressurable first-word-fall-through AXI-Stream master.
// Bytes that arrive with no free slot are dropped and flagged in a sticky
// overflow bit.
// Optional build macro UART_RX_FIFO_DROP_CNT_EN adds a saturating drop_cnt
// output that counts discarded bytes.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;

  logic w_not_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake decode; a pop frees the slot the same cycle, so a full FIFO
  // being read can still accept the incoming byte.
  assign w_not_full    = (r_level < LVL_W'(DEPTH));
  assign m_axis_tvalid = (r_level != '0);
  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign w_push        = s_axis_tvalid & (w_not_full | w_pop);
  assign w_drop        = s_axis_tvalid & ~w_push;
  assign s_axis_tready = w_not_full | m_axis_tready;

  // Head byte is forced to zero while empty so stale memory never leaks out.
  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
  assign level         = r_level;
  assign overflow      = r_overflow;

  // Storage array; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_axis_tdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Saturating drop counter; a drop during a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (overflow_clr) begin
        r_drop_cnt <= 16'd1;
      end else if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (overflow_clr) begin
      r_drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [4:0]    level;
  logic          overflow;
  logic          ovf_clr;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf;
  int            m_dcnt;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (ovf_clr)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of one clock: pop the head if offered and accepted, append the
  // incoming byte if there is room after the pop, else record a drop.
  task automatic model_clk();
    bit pop, push, drop;
    pop  = (q.size() != 0) && m_tready;
    push = s_tvalid && ((q.size() < DEPTH) || pop);
    drop = s_tvalid && !push;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(s_tdata);
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (drop) m_dcnt = ovf_clr ? 1 : ((m_dcnt < 65535) ? m_dcnt + 1 : 65535);
    else if (ovf_clr) m_dcnt = 0;
  endtask

  // Apply inputs at the falling edge, clock once, return at next falling edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = rdy;
    ovf_clr  = clr;
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0; ovf_clr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_dcnt = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    n_cmp++; if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got=%h exp=00", m_tdata); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    // Mid-stream: fill, overflow once, drain down to 5 entries, then reset.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i + 8'h10), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (level !== 5'd5) begin n_err++; $display("FAIL rst_pre_level got=%0d exp=5", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rst_pre_ovf got=%b exp=1", overflow); end
    s_tvalid = 1'b0; m_tready = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_dcnt = 0;
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_mid_level got=%0d exp=0", level); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_mid_tvalid got=%b exp=0", m_tvalid); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
    n_cmp++; if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_mid_tdata got=%h exp=00", m_tdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL pt_tvalid got=%b exp=1", m_tvalid); end
    n_cmp++; if (m_tdata !== 8'hA5) begin n_err++; $display("FAIL pt_tdata got=%h exp=a5", m_tdata); end
    n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL pt_level1 got=%0d exp=1", level); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL pt_level0 got=%0d exp=0", level); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL pt_tvalid0 got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_order_wrap();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(b * 16 + i), 1'b0, 1'b0);
      n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ow_level got=%0d exp=16", level); end
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL ow_tready_full got=%b exp=0", s_tready); end
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (m_tvalid !== 1'b1 || m_tdata !== 8'(b * 16 + i)) begin
          n_err++; $display("FAIL ow_data got=%b/%h exp=1/%h", m_tvalid, m_tdata, 8'(b * 16 + i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
      end
      n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL ow_drained got=%0d exp=0", level); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got=%0d exp=16", level); end
    n_cmp++; if (m_tdata !== 8'h40) begin n_err++; $display("FAIL ovf_head got=%h exp=40", m_tdata); end
    // Drop coinciding with clear: overflow must remain set.
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_setwins got=%b exp=1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (m_tdata !== 8'(8'h40 + i)) begin n_err++; $display("FAIL ovf_drain got=%h exp=%h", m_tdata, 8'(8'h40 + i)); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got=%b exp=0", m_tvalid); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    m_tready = 1'b1;
    #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL fpp_tready got=%b exp=1", s_tready); end
    drive(1'b1, 8'h3C, 1'b1, 1'b0);
    n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL fpp_level got=%0d exp=16", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_nodrop got=%b exp=0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (m_tdata !== ((i < DEPTH - 1) ? 8'(8'h81 + i) : 8'h3C)) begin
        n_err++; $display("FAIL fpp_drain got=%h exp=%h", m_tdata, (i < DEPTH - 1) ? 8'(8'h81 + i) : 8'h3C);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic          v, rdy, clr;
    logic [DW-1:0] d;
    int            rdy_pct;
    for (int c = 0; c < 800; c++) begin
      rdy_pct = ((c / 60) % 2 == 0) ? 25 : 85;
      v   = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < rdy_pct);
      clr = ($urandom_range(99) < 4);
      d   = 8'($urandom);
      s_tvalid = v; s_tdata = d; m_tready = rdy; ovf_clr = clr;
      #1;
      n_cmp++;
      if (m_tvalid !== (q.size() != 0) || level !== 5'(q.size())) begin
        n_err++; $display("FAIL rnd_state c=%0d got=%b/%0d exp=%b/%0d", c, m_tvalid, level, q.size() != 0, q.size());
      end
      n_cmp++;
      if (m_tdata !== ((q.size() != 0) ? q[0] : 8'h00)) begin
        n_err++; $display("FAIL rnd_tdata c=%0d got=%h exp=%h", c, m_tdata, (q.size() != 0) ? q[0] : 8'h00);
      end
      n_cmp++;
      if (s_tready !== ((q.size() < DEPTH) || rdy)) begin
        n_err++; $display("FAIL rnd_s_tready c=%0d got=%b exp=%b", c, s_tready, (q.size() < DEPTH) || rdy);
      end
      n_cmp++;
      if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
`ifdef UART_RX_FIFO_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 16'(m_dcnt)) begin n_err++; $display("FAIL rnd_drop_cnt c=%0d got=%0d exp=%0d", c, drop_cnt, m_dcnt); end
`endif
      drive(v, d, rdy, clr);
    end
    for (int i = 0; i <= DEPTH; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rnd_final_level got=%0d exp=0", level); end
  endtask

`ifdef UART_RX_FIFO_DROP_CNT_EN
  task automatic test_drop_cnt();
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL dc_start got=%0d exp=0", drop_cnt); end
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hD0, 1'b0, 1'b0);
    n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL dc_three got=%0d exp=3", drop_cnt); end
    drive(1'b1, 8'hD1, 1'b0, 1'b1);
    n_cmp++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL dc_clr_drop got=%0d exp=1", drop_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL dc_clr_ovf got=%b exp=1", overflow); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL dc_cleared got=%0d exp=0", drop_cnt); end
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_order_wrap();
    test_overflow();
    test_full_push_pop();
    test_random();
`ifdef UART_RX_FIFO_DROP_CNT_EN
    test_drop_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
